// File: rtl/vga_plot_engine.sv
// rtl/vga_plot_engine.sv - command FIFO plus pixel/rectangle rasteriser driving the VGA plot bus
// One pixel per unstalled cycle; off-screen pixels are clipped but still take a raster slot.
module vga_plot_engine #(
  parameter int H_RES      = 320,
  parameter int V_RES      = 240,
  parameter int X_BITS     = 9,
  parameter int Y_BITS     = 8,
  parameter int COLOR_BITS = 24,
  parameter int DEPTH      = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic                  i_cmd_rect,
  input  logic [X_BITS-1:0]     i_cmd_x,
  input  logic [Y_BITS-1:0]     i_cmd_y,
  input  logic [X_BITS-1:0]     i_cmd_w,
  input  logic [Y_BITS-1:0]     i_cmd_h,
  input  logic [COLOR_BITS-1:0] i_cmd_color,
  input  logic                  i_vga_stall,
  output logic [X_BITS-1:0]     o_vga_x,
  output logic [Y_BITS-1:0]     o_vga_y,
  output logic [COLOR_BITS-1:0] o_vga_color,
  output logic                  o_vga_plot,
  output logic                  o_busy
);
  localparam int PTR_BITS = $clog2(DEPTH);
  localparam int CMD_BITS = 1 + 2 * X_BITS + 2 * Y_BITS + COLOR_BITS;
  localparam int XW       = X_BITS + 1;
  localparam int YW       = Y_BITS + 1;
  localparam logic [XW-1:0] H_LIM = XW'(H_RES);
  localparam logic [YW-1:0] V_LIM = YW'(V_RES);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  logic [CMD_BITS-1:0]   r_mem [DEPTH];
  logic [PTR_BITS-1:0]   r_wr_ptr;
  logic [PTR_BITS-1:0]   r_rd_ptr;
  logic [PTR_BITS:0]     r_count;
  state_t                r_state;
  state_t                w_state_next;
  logic [XW-1:0]         r_x0;
  logic [XW-1:0]         r_cur_x;
  logic [XW-1:0]         r_x_end;
  logic [YW-1:0]         r_cur_y;
  logic [YW-1:0]         r_y_end;
  logic [COLOR_BITS-1:0] r_color;
  logic [X_BITS-1:0]     r_vga_x;
  logic [Y_BITS-1:0]     r_vga_y;
  logic [COLOR_BITS-1:0] r_vga_color;
  logic                  r_vga_plot;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_emit;
  logic                  w_last;
  logic                  w_h_rect;
  logic [X_BITS-1:0]     w_h_x;
  logic [Y_BITS-1:0]     w_h_y;
  logic [X_BITS-1:0]     w_h_w;
  logic [Y_BITS-1:0]     w_h_h;
  logic [COLOR_BITS-1:0] w_h_color;
  logic                  w_h_zero;

  assign w_full      = (r_count == (PTR_BITS + 1)'(DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_push      = i_cmd_valid && !w_full;
  assign o_cmd_ready = !w_full;

  assign {w_h_rect, w_h_x, w_h_y, w_h_w, w_h_h, w_h_color} = r_mem[r_rd_ptr];
  assign w_h_zero = w_h_rect && ((w_h_w == '0) || (w_h_h == '0));
  assign w_last   = (r_cur_x == r_x_end) && (r_cur_y == r_y_end);

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {i_cmd_rect, i_cmd_x, i_cmd_y, i_cmd_w, i_cmd_h, i_cmd_color};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  // A popped zero-area rectangle is simply discarded, leaving the FSM idle.
  always_comb begin
    w_state_next = r_state;
    if (!i_vga_stall) begin
      case (r_state)
        S_IDLE:  if (!w_empty && !w_h_zero) w_state_next = S_RUN;
        S_RUN:   if (w_last) w_state_next = (!w_empty && !w_h_zero) ? S_RUN : S_IDLE;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_pop  = 1'b0;
    w_emit = 1'b0;
    if (!i_vga_stall) begin
      case (r_state)
        S_IDLE:  w_pop = !w_empty;
        S_RUN: begin
          w_emit = 1'b1;
          w_pop  = w_last && !w_empty;
        end
        default: w_pop = 1'b0;
      endcase
    end
  end

  // Counters are one bit wider than the coordinates so raster ends never wrap.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_x0        <= '0;
      r_cur_x     <= '0;
      r_x_end     <= '0;
      r_cur_y     <= '0;
      r_y_end     <= '0;
      r_color     <= '0;
      r_vga_x     <= '0;
      r_vga_y     <= '0;
      r_vga_color <= '0;
      r_vga_plot  <= 1'b0;
    end else if (!i_vga_stall) begin
      if (w_emit) begin
        r_vga_x     <= r_cur_x[X_BITS-1:0];
        r_vga_y     <= r_cur_y[Y_BITS-1:0];
        r_vga_color <= r_color;
        r_vga_plot  <= (r_cur_x < H_LIM) && (r_cur_y < V_LIM);
      end else begin
        r_vga_plot  <= 1'b0;
      end
      if (w_pop) begin
        r_x0    <= {1'b0, w_h_x};
        r_cur_x <= {1'b0, w_h_x};
        r_cur_y <= {1'b0, w_h_y};
        r_color <= w_h_color;
        r_x_end <= w_h_rect ? ({1'b0, w_h_x} + {1'b0, w_h_w} - XW'(1)) : {1'b0, w_h_x};
        r_y_end <= w_h_rect ? ({1'b0, w_h_y} + {1'b0, w_h_h} - YW'(1)) : {1'b0, w_h_y};
      end else if (w_emit) begin
        if (r_cur_x == r_x_end) begin
          r_cur_x <= r_x0;
          r_cur_y <= r_cur_y + 1'b1;
        end else begin
          r_cur_x <= r_cur_x + 1'b1;
        end
      end
    end
  end

  assign o_vga_x     = r_vga_x;
  assign o_vga_y     = r_vga_y;
  assign o_vga_color = r_vga_color;
  assign o_vga_plot  = r_vga_plot;
  assign o_busy      = !w_empty || (r_state != S_IDLE) || r_vga_plot;

endmodule

// File: tb/tb_vga_plot_engine.sv
// tb/tb_vga_plot_engine.sv - directed and randomised bench for vga_plot_engine
// Expected pixels come from a raster model that expands each accepted command into a queue.
module tb_vga_plot_engine;
  localparam int H_RES = 320;
  localparam int V_RES = 240;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_rect;
  logic [8:0]  cmd_x;
  logic [7:0]  cmd_y;
  logic [8:0]  cmd_w;
  logic [7:0]  cmd_h;
  logic [23:0] cmd_color;
  logic        vga_stall;
  logic [8:0]  vga_x;
  logic [7:0]  vga_y;
  logic [23:0] vga_color;
  logic        vga_plot;
  logic        busy;

  always #5 clk = ~clk;

  vga_plot_engine dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_cmd_valid (cmd_valid),
    .o_cmd_ready (cmd_ready),
    .i_cmd_rect  (cmd_rect),
    .i_cmd_x     (cmd_x),
    .i_cmd_y     (cmd_y),
    .i_cmd_w     (cmd_w),
    .i_cmd_h     (cmd_h),
    .i_cmd_color (cmd_color),
    .i_vga_stall (vga_stall),
    .o_vga_x     (vga_x),
    .o_vga_y     (vga_y),
    .o_vga_color (vga_color),
    .o_vga_plot  (vga_plot),
    .o_busy      (busy)
  );

  typedef struct {int x; int y; int c;} pix_t;
  pix_t exp_q[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_cmd(input bit rect, input int x, input int y, input int w, input int h, input int c);
    pix_t p;
    if (!rect) begin
      w = 1;
      h = 1;
    end
    for (int j = 0; j < h; j++)
      for (int i = 0; i < w; i++)
        if (x + i < H_RES && y + j < V_RES) begin
          p.x = x + i;
          p.y = y + j;
          p.c = c;
          exp_q.push_back(p);
        end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit rect, input int x, input int y, input int w, input int h,
                      input int c, input bit rnd_stall);
    bit acc = 1'b0;
    int n = 0;
    cmd_rect  = rect;
    cmd_x     = 9'(x);
    cmd_y     = 8'(y);
    cmd_w     = 9'(w);
    cmd_h     = 8'(h);
    cmd_color = 24'(c);
    cmd_valid = 1'b1;
    while (!acc && n < 200) begin
      if (rnd_stall) vga_stall = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      acc = cmd_ready;
      sync();
      n++;
    end
    cmd_valid = 1'b0;
    chk("push_accept", 64'(acc), 64'd1);
    if (acc) model_cmd(rect, x, y, w, h, c);
  endtask

  task automatic wait_idle(input bit rnd_stall);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 20000) begin
      if (rnd_stall) vga_stall = ($urandom_range(0, 2) == 0);
      sync();
      n++;
    end
    vga_stall = 1'b0;
    chk("idle_reached", 64'(n < 20000), 64'd1);
    chk("exp_drained", 64'(exp_q.size()), 64'd0);
  endtask

  // Scoreboard and stall-hold monitor.
  logic        p_stall = 1'b0;
  logic        p_reset = 1'b1;
  logic [8:0]  p_x;
  logic [7:0]  p_y;
  logic [23:0] p_c;
  logic        p_plot;
  always @(negedge clk) begin
    pix_t e;
    if (p_stall && !p_reset) begin
      chk("hold_x", 64'(vga_x), 64'(p_x));
      chk("hold_y", 64'(vga_y), 64'(p_y));
      chk("hold_color", 64'(vga_color), 64'(p_c));
      chk("hold_plot", 64'(vga_plot), 64'(p_plot));
    end
    if (vga_plot && !vga_stall) begin
      if (exp_q.size() == 0) chk("unexpected_pixel", 64'd1, 64'd0);
      else begin
        e = exp_q.pop_front();
        chk("pix_x", 64'(vga_x), 64'(e.x));
        chk("pix_y", 64'(vga_y), 64'(e.y));
        chk("pix_color", 64'(vga_color), 64'(e.c));
      end
    end
    p_stall = vga_stall;
    p_reset = reset;
    p_x     = vga_x;
    p_y     = vga_y;
    p_c     = vga_color;
    p_plot  = vga_plot;
  end

  initial begin
    int first;
    int last;
    int pc;
    int n;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_rect  = 1'b0;
    cmd_x     = '0;
    cmd_y     = '0;
    cmd_w     = '0;
    cmd_h     = '0;
    cmd_color = '0;
    vga_stall = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(cmd_ready), 64'd1);
    chk("rst_plot", 64'(vga_plot), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_x", 64'(vga_x), 64'd0);
    chk("rst_color", 64'(vga_color), 64'd0);
    sync();
    reset = 1'b0;

    // single pixel latency
    push(1'b0, 5, 7, 0, 0, 24'hFF0000, 1'b0);
    @(negedge clk);
    chk("t1_plot_e0", 64'(vga_plot), 64'd0);
    @(negedge clk);
    chk("t1_plot_e1", 64'(vga_plot), 64'd0);
    @(negedge clk);
    chk("t1_plot_e2", 64'(vga_plot), 64'd1);
    chk("t1_x", 64'(vga_x), 64'd5);
    chk("t1_y", 64'(vga_y), 64'd7);
    chk("t1_color", 64'(vga_color), 64'hFF0000);
    @(negedge clk);
    chk("t1_plot_e3", 64'(vga_plot), 64'd0);
    chk("t1_busy", 64'(busy), 64'd0);
    sync();

    // 3x2 rectangle followed back-to-back by a pixel
    push(1'b1, 10, 20, 3, 2, 24'h00AA55, 1'b0);
    push(1'b0, 99, 99, 0, 0, 24'h123456, 1'b0);
    n = 0;
    @(negedge clk);
    while (!vga_plot && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t2_started", 64'(n < 20), 64'd1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("t2_no_bubble", 64'(vga_plot), 64'd1);
    end
    @(negedge clk);
    chk("t2_end", 64'(vga_plot), 64'd0);
    sync();
    wait_idle(1'b0);

    // fill the FIFO while stalled
    vga_stall = 1'b1;
    for (int i = 0; i < 8; i++)
      push(1'(i % 2), $urandom_range(0, 300), $urandom_range(0, 230),
           $urandom_range(1, 3), $urandom_range(1, 2), int'($urandom_range(0, 24'hFFFFFF)), 1'b0);
    @(negedge clk);
    chk("t3_full_ready", 64'(cmd_ready), 64'd0);
    chk("t3_full_busy", 64'(busy), 64'd1);
    chk("t3_full_plot", 64'(vga_plot), 64'd0);
    sync();
    cmd_rect  = 1'b1;
    cmd_x     = 9'd40;
    cmd_y     = 8'd41;
    cmd_w     = 9'd2;
    cmd_h     = 8'd2;
    cmd_color = 24'h0F0F0F;
    cmd_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t3_ninth_held", 64'(cmd_ready), 64'd0);
      sync();
    end
    vga_stall = 1'b0;
    @(negedge clk);
    chk("t3_no_pushthrough", 64'(cmd_ready), 64'd0);
    sync();
    @(negedge clk);
    chk("t3_ready_after_pop", 64'(cmd_ready), 64'd1);
    sync();
    cmd_valid = 1'b0;
    model_cmd(1'b1, 40, 41, 2, 2, 24'h0F0F0F);
    wait_idle(1'b1);

    // clipping at the bottom-right corner
    push(1'b1, 318, 238, 4, 4, 24'hABCDEF, 1'b0);
    first = -1;
    last  = -1;
    pc    = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (vga_plot) begin
        if (first < 0) first = k;
        last = k;
        pc++;
      end
    end
    chk("t4_count", 64'(pc), 64'd4);
    chk("t4_span", 64'(last - first), 64'd5);
    sync();
    wait_idle(1'b0);

    // zero-width rectangle ahead of a pixel
    push(1'b1, 50, 50, 0, 3, 24'h777777, 1'b0);
    push(1'b0, 1, 1, 0, 0, 24'h00FF00, 1'b0);
    @(negedge clk);
    chk("t5_plot_e1", 64'(vga_plot), 64'd0);
    @(negedge clk);
    chk("t5_plot_e2", 64'(vga_plot), 64'd0);
    @(negedge clk);
    chk("t5_plot_e3", 64'(vga_plot), 64'd1);
    chk("t5_x", 64'(vga_x), 64'd1);
    chk("t5_y", 64'(vga_y), 64'd1);
    sync();
    wait_idle(1'b0);

    // reset mid clear-screen
    push(1'b1, 0, 0, 320, 240, 24'h000000, 1'b0);
    repeat (50) sync();
    chk("t6_running", 64'(vga_plot), 64'd1);
    reset = 1'b1;
    sync();
    exp_q.delete();
    @(negedge clk);
    chk("t6_plot", 64'(vga_plot), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_ready", 64'(cmd_ready), 64'd1);
    sync();
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("t6_quiet", 64'(vga_plot), 64'd0);
    end
    sync();

    // randomised commands with random stalls, including far off-screen starts
    for (int t = 0; t < 40; t++)
      push(1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) == 0) ? $urandom_range(480, 511) : $urandom_range(0, 340),
           $urandom_range(0, 250), $urandom_range(0, 6), $urandom_range(0, 4),
           int'($urandom_range(0, 24'hFFFFFF)), 1'b1);
    wait_idle(1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
